demux8_reg: RTL and testbench
=============================

# demux8_reg

Registered 1-to-8 demultiplexer with a burst-write sequencer. It is the distribution counterpart of the datapath selectors: one N-bit source word is steered into one of eight held output registers. Writes are either single, addressed by `sel`, or a burst of consecutive words to consecutive channels. It feeds output-port latches and the monitor's register-load path.

## Interface
- `N`, default 8: data width of the input and of each output register.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset. Clears all state on the clock edge where it is sampled high.
- `sel`  in  3  channel address for a single write; base channel for a burst.
- `d`  in  N  write data.
- `we`  in  1  single-write strobe. Honoured only in IDLE.
- `start`  in  1  burst start. Honoured only in IDLE.
- `len`  in  3  burst length minus one (0 = 1 word, 7 = 8 words). Sampled with `start`.
- `valid`  in  1  burst data strobe. Honoured only in BURST.
- `ready`  out  1  high while in BURST (accepting burst words).
- `y0`..`y7`  out  N each  held output registers.
- `upd`  out  8  one-hot, one-cycle pulse marking the channel written on the preceding edge.

## Operation
- States: IDLE, BURST. Internal registers: `ptr[2:0]` (next channel) and `rem[2:0]` (words remaining minus one).
- On reset: state = IDLE, all `y0..y7` = 0, `upd` = 0, `ptr` = 0, `rem` = 0, `ready` = 0.
- IDLE, `start` = 1:
  - go to BURST.
  - `ptr` ← `sel`, `rem` ← `len`.
  - No output is written. `we` in the same cycle is ignored, because `start` has priority.
- IDLE, `we` = 1, `start` = 0:
  - `y[sel]` ← `d`.
  - `upd` ← one-hot(`sel`).
  - State stays IDLE.
- IDLE, `valid` = 1: ignored.
- BURST, `valid` = 1:
  - `y[ptr]` ← `d`, `upd` ← one-hot(`ptr`).
  - `ptr` ← `ptr`+1 modulo 8, so 7 wraps to 0.
  - If `rem` = 0, return to IDLE. Otherwise `rem` ← `rem`−1.
- BURST, `valid` = 0: hold all state. There is no timeout.
- BURST: `we` and `start` are ignored.
- A burst with `len` = 7 writes all eight channels exactly once, starting at `sel`.
- `upd` is 0 in every cycle that follows an edge with no accepted write.
- Outputs not being written hold their value indefinitely.
- Reset mid-burst: it aborts the burst and zeroes all outputs. No partial state is retained.

## Timing
- All outputs are registered, except `ready`, which is decoded directly from the state register.
- Write latency is one edge: `y[k]` shows the new value in the cycle after the accepting edge, and `upd[k]` is high in that same cycle only.
- `start` accepted at edge t: `ready` = 1 from cycle t+1. The first burst word can be accepted at edge t+1.
- Last burst word accepted at edge t: `ready` = 0 from cycle t+1. A new `we` or `start` is accepted at edge t+1.
- Burst throughput is one word per cycle when `valid` is held high.
- `reset` overrides every other input on the same edge.

## Test plan
- Reset → all `yk` = 0, `upd` = 0, `ready` = 0. Then `we`=1, `sel`=5, `d`=8'hA5 for one cycle → next cycle `y5`=A5, `upd`=8'b0010_0000, all other outputs 0. One cycle later `upd`=0.
- Burst with wrap: `start`, `sel`=6, `len`=2, then `valid` high for 3 cycles with `d`=11, 22, 33.
  - Required: `y6`=11, `y7`=22, `y0`=33.
  - `upd` sequence: bit 6, bit 7, bit 0.
  - `ready` drops the cycle after the third word is accepted.
- Stalled burst: `len`=1 with `valid` gaps of 3 cycles between words.
  - `ready` stays 1 across the gaps and `upd` is 0 during the gaps.
  - Exactly 2 channels are written.
- Priority and ignored strobes:
  - `we` and `start` together in IDLE → no write; BURST is entered.
  - `we`=1 during BURST → no write.
  - `valid`=1 in IDLE → no write.
- Full burst: `sel`=3, `len`=7, data 1..8 → `y3..y7`=1..5, `y0..y2`=6..8. Returns to IDLE after exactly 8 accepted words.
- Reset mid-burst: after 2 of 5 words, assert `reset` → all outputs 0, `ready`=0. A following `valid` writes nothing, and a following `we` to channel 2 succeeds.

Source files
------------

// File: rtl/demux8_reg.sv
// demux8_reg: registered 1-to-8 demultiplexer with single and burst writes.
// Rev 1.0 - initial release.
`default_nettype none

module demux8_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   sel,
  input  logic [N-1:0] d,
  input  logic         we,
  input  logic         start,
  input  logic [2:0]   len,
  input  logic         valid,
  output logic         ready,
  output logic [N-1:0] y0,
  output logic [N-1:0] y1,
  output logic [N-1:0] y2,
  output logic [N-1:0] y3,
  output logic [N-1:0] y4,
  output logic [N-1:0] y5,
  output logic [N-1:0] y6,
  output logic [N-1:0] y7,
  output logic [7:0]   upd
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [2:0]   ptr, ptr_nxt;
  logic [2:0]   rem, rem_nxt;
  logic         wr_en;
  logic [2:0]   wr_ch;
  logic [N-1:0] y_q [8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 3'd0;
      rem   <= 3'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      rem   <= rem_nxt;
    end
  end

  // start wins over we in IDLE; in BURST only valid matters.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rem_nxt   = rem;
    wr_en     = 1'b0;
    wr_ch     = sel;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BURST;
          ptr_nxt   = sel;
          rem_nxt   = len;
        end else if (we) begin
          wr_en = 1'b1;
          wr_ch = sel;
        end
      end
      BURST: begin
        if (valid) begin
          wr_en   = 1'b1;
          wr_ch   = ptr;
          ptr_nxt = ptr + 3'd1;
          if (rem == 3'd0) begin
            state_nxt = IDLE;
          end else begin
            rem_nxt = rem - 3'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd <= 8'd0;
      for (int k = 0; k < 8; k++) begin
        y_q[k] <= '0;
      end
    end else begin
      upd <= wr_en ? (8'd1 << wr_ch) : 8'd0;
      if (wr_en) begin
        y_q[wr_ch] <= d;
      end
    end
  end

  assign ready = (state == BURST);
  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];
  assign y4 = y_q[4];
  assign y5 = y_q[5];
  assign y6 = y_q[6];
  assign y7 = y_q[7];

endmodule

`default_nettype wire

// File: tb/tb_demux8_reg.sv
// Scoreboard bench for demux8_reg: expected writes are queued by the stimulus
// and popped by a monitor whenever upd pulses.
`default_nettype none

module tb_demux8_reg;

  logic       clk = 1'b0;
  logic       reset, we, start, valid;
  logic [2:0] sel, len;
  logic [7:0] d;
  logic       ready;
  logic [7:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0] upd;

  demux8_reg #(.N(8)) dut (
    .clk(clk), .reset(reset), .sel(sel), .d(d), .we(we), .start(start),
    .len(len), .valid(valid), .ready(ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .upd(upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  logic [7:0]  yv [8];
  logic [63:0] yall;
  assign yv[0] = y0; assign yv[1] = y1; assign yv[2] = y2; assign yv[3] = y3;
  assign yv[4] = y4; assign yv[5] = y5; assign yv[6] = y6; assign yv[7] = y7;
  assign yall = {y7, y6, y5, y4, y3, y2, y1, y0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [7:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    q.push_back(e);
  endtask

  // Monitor: every upd pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!$isunknown(upd) && upd != 8'd0) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: upd=%b with empty scoreboard", upd);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_upd", 64'(upd), 64'(8'd1 << e.ch));
        chk("mon_data", 64'(yv[e.ch]), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; we = 1'b0; start = 1'b0; valid = 1'b0;
    sel = 3'd0; len = 3'd0; d = 8'd0;
    step(); step();
    chk("reset_y", yall, 64'd0);
    chk("reset_upd", 64'(upd), 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    reset = 1'b0;

    // single write
    we = 1'b1; sel = 3'd5; d = 8'hA5; push(5, 8'hA5);
    step();
    we = 1'b0;
    chk("single_y", yall, 64'h0000_A500_0000_0000);
    chk("single_upd", 64'(upd), 64'h20);
    chk("single_ready", 64'(ready), 64'd0);
    step();
    chk("single_upd_clear", 64'(upd), 64'd0);

    // burst with wrap 6,7,0
    start = 1'b1; sel = 3'd6; len = 3'd2;
    step();
    start = 1'b0;
    chk("wrap_ready_on", 64'(ready), 64'd1);
    valid = 1'b1; d = 8'h11; push(6, 8'h11); step();
    d = 8'h22; push(7, 8'h22); step();
    d = 8'h33; push(0, 8'h33);
    chk("wrap_ready_before_last", 64'(ready), 64'd1);
    step();
    valid = 1'b0;
    chk("wrap_ready_off", 64'(ready), 64'd0);
    chk("wrap_y", yall, 64'h2211_A500_0000_0033);

    // stalled burst, len=1, gaps of 3 cycles
    start = 1'b1; sel = 3'd1; len = 3'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready_pre", 64'(ready), 64'd1);
      chk("stall_upd_pre", 64'(upd), 64'd0);
    end
    valid = 1'b1; d = 8'h44; push(1, 8'h44);
    step();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready_gap", 64'(ready), 64'd1);
      chk("stall_upd_gap", 64'(upd), 64'd0);
    end
    valid = 1'b1; d = 8'h55; push(2, 8'h55);
    step();
    valid = 1'b0;
    step();
    chk("stall_ready_off", 64'(ready), 64'd0);
    chk("stall_y", yall, 64'h2211_A500_0055_4433);

    // start has priority over we; we ignored in BURST; valid ignored in IDLE
    we = 1'b1; start = 1'b1; sel = 3'd4; len = 3'd0; d = 8'hEE;
    step();
    we = 1'b0; start = 1'b0;
    chk("prio_ready", 64'(ready), 64'd1);
    chk("prio_upd", 64'(upd), 64'd0);
    we = 1'b1; sel = 3'd3; d = 8'hDD;
    step();
    we = 1'b0;
    chk("burst_we_upd", 64'(upd), 64'd0);
    chk("burst_we_ready", 64'(ready), 64'd1);
    valid = 1'b1; d = 8'h66; push(4, 8'h66);
    step();
    valid = 1'b0;
    chk("prio_done_ready", 64'(ready), 64'd0);
    valid = 1'b1; sel = 3'd3; d = 8'h77;
    step();
    valid = 1'b0;
    step();
    chk("idle_valid_upd", 64'(upd), 64'd0);
    chk("prio_y", yall, 64'h2211_A566_0055_4433);

    // full 8-word burst from channel 3
    start = 1'b1; sel = 3'd3; len = 3'd7;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; d = 8'(i + 1); push((3 + i) % 8, 8'(i + 1));
      chk("full_ready", 64'(ready), 64'd1);
      step();
    end
    valid = 1'b0;
    chk("full_ready_off", 64'(ready), 64'd0);
    chk("full_y", yall, 64'h0504_0302_0108_0706);

    // reset mid-burst after 2 of 5 words
    start = 1'b1; sel = 3'd0; len = 3'd4;
    step();
    start = 1'b0;
    valid = 1'b1; d = 8'hA1; push(0, 8'hA1); step();
    d = 8'hA2; push(1, 8'hA2); step();
    valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset_y", yall, 64'd0);
    chk("mid_reset_ready", 64'(ready), 64'd0);
    chk("mid_reset_upd", 64'(upd), 64'd0);
    valid = 1'b1; d = 8'hBB;
    step();
    valid = 1'b0;
    chk("post_reset_valid_upd", 64'(upd), 64'd0);
    chk("post_reset_valid_y", yall, 64'd0);
    we = 1'b1; sel = 3'd2; d = 8'hCC; push(2, 8'hCC);
    step();
    we = 1'b0;
    chk("post_reset_we_y", yall, 64'h0000_0000_00CC_0000);
    chk("post_reset_we_upd", 64'(upd), 64'h04);

    step(); step();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
